except_redirect_ctrl: RTL and testbench

//  Precise-exception and ERET controller. Drives the PC register's clear/except_pc redirect input.

---
 rtl/except_redirect_ctrl_pkg.sv | 64 ++++++
 rtl/except_redirect_ctrl_cp0_timer.sv | 55 +++++
 rtl/except_redirect_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_except_redirect_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/except_redirect_ctrl_pkg.sv
// Shared definitions for the exception/ERET redirect controller.
// Covers CP0 register numbers, ExcCodes, the entry vector, field positions and word packers.
package except_redirect_ctrl_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int STATUS_BEV_BIT = 22;
  localparam int CAUSE_EXC_LSB  = 2;
  localparam int CAUSE_IP_LSB   = 8;
  localparam int CAUSE_TI_BIT   = 30;
  localparam int CAUSE_BD_BIT   = 31;

  // Bit positions inside exc_flags = {adel_if, ri, ov, sys, bp, adel_ld, ades}
  localparam int FLAG_ADEL_IF = 6;
  localparam int FLAG_RI      = 5;
  localparam int FLAG_OV      = 4;
  localparam int FLAG_SYS     = 3;
  localparam int FLAG_BP      = 2;
  localparam int FLAG_ADEL_LD = 1;
  localparam int FLAG_ADES    = 0;

  typedef enum logic {ST_IDLE, ST_REDIR} redir_state_e;

  function automatic logic [31:0] status_word(input logic [7:0] im, input logic exl,
                                              input logic ie);
    logic [31:0] w;
    w = '0;
    w[STATUS_BEV_BIT] = 1'b1;
    w[STATUS_IM_LSB +: 8] = im;
    w[STATUS_EXL_BIT] = exl;
    w[STATUS_IE_BIT] = ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input logic bd, input logic ti,
                                             input logic [7:0] ip, input logic [4:0] exc);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD_BIT] = bd;
    w[CAUSE_TI_BIT] = ti;
    w[CAUSE_IP_LSB +: 8] = ip;
    w[CAUSE_EXC_LSB +: 5] = exc;
    return w;
  endfunction

endpackage

// File: rtl/except_redirect_ctrl_cp0_timer.sv
// CP0 Count/Compare pair: Count advances every other cycle, TI flags a Compare match.
module except_redirect_ctrl_cp0_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_we,
  input  logic             compare_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output logic             ti
);

  logic             toggle_q, toggle_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  logic             ti_q, ti_d;

  always_comb begin
    toggle_d  = ~toggle_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (toggle_q) begin
      count_d = count_q + WIDTH'(1);
      if (count_d == compare_q) ti_d = 1'b1;
    end
    // A software write to Count replaces this cycle's increment
    if (count_we) count_d = wdata;
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_q  <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/except_redirect_ctrl.sv
// Precise exception / ERET controller at the MEM/WB boundary: CP0 subset, flush and PC redirect.
module except_redirect_ctrl
  import except_redirect_ctrl_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_pc,
  input  logic             mem_bd,
  input  logic [WIDTH-1:0] mem_badaddr,
  input  logic [6:0]       exc_flags,
  input  logic             eret,
  input  logic [5:0]       hw_int,
  input  logic             stall,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_waddr,
  input  logic [WIDTH-1:0] cp0_wdata,
  input  logic [4:0]       cp0_raddr,
  output logic [WIDTH-1:0] cp0_rdata,
  output logic             flush,
  output logic             pc_clear,
  output logic [WIDTH-1:0] except_pc
);

  redir_state_e     state_q, state_d;
  logic             flush_q, flush_d, pc_clear_q, pc_clear_d;
  logic [WIDTH-1:0] except_pc_q, except_pc_d;
  logic [7:0]       status_im_q, status_im_d;
  logic             status_exl_q, status_exl_d, status_ie_q, status_ie_d;
  logic             cause_bd_q, cause_bd_d;
  logic [5:0]       cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]       cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]       cause_exc_q, cause_exc_d;
  logic [WIDTH-1:0] epc_q, epc_d, badvaddr_q, badvaddr_d;

  logic             int_p, exc_take, accept, mtc0_en, badv_we;
  logic [4:0]       exc_code;
  logic [WIDTH-1:0] badv_val;
  logic             count_we, compare_we, timer_ti;
  logic [WIDTH-1:0] timer_count, timer_compare;

  except_redirect_ctrl_cp0_timer #(.WIDTH(WIDTH)) u_cp0_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (cp0_wdata),
    .count      (timer_count),
    .compare    (timer_compare),
    .ti         (timer_ti)
  );

  always_comb begin
    int_p    = status_ie_q & ~status_exl_q & |({cause_ip_hw_q, cause_ip_sw_q} & status_im_q);
    exc_take = 1'b1;
    exc_code = EXC_INT;
    badv_we  = 1'b0;
    badv_val = mem_badaddr;
    if (int_p) exc_code = EXC_INT;
    else if (exc_flags[FLAG_ADEL_IF]) begin
      exc_code = EXC_ADEL;
      badv_we  = 1'b1;
      badv_val = mem_pc;
    end
    else if (exc_flags[FLAG_RI])  exc_code = EXC_RI;
    else if (exc_flags[FLAG_OV])  exc_code = EXC_OV;
    else if (exc_flags[FLAG_SYS]) exc_code = EXC_SYS;
    else if (exc_flags[FLAG_BP])  exc_code = EXC_BP;
    else if (exc_flags[FLAG_ADEL_LD]) begin
      exc_code = EXC_ADEL;
      badv_we  = 1'b1;
    end
    else if (exc_flags[FLAG_ADES]) begin
      exc_code = EXC_ADES;
      badv_we  = 1'b1;
    end
    else exc_take = 1'b0;
    accept  = (state_q == ST_IDLE) & mem_valid & ~stall & (exc_take | eret);
    mtc0_en = cp0_we & ~accept;
  end

  assign count_we   = mtc0_en & (cp0_waddr == CP0_COUNT);
  assign compare_we = mtc0_en & (cp0_waddr == CP0_COMPARE);

  always_comb begin
    state_d       = state_q;
    flush_d       = flush_q;
    pc_clear_d    = pc_clear_q;
    except_pc_d   = except_pc_q;
    status_im_d   = status_im_q;
    status_exl_d  = status_exl_q;
    status_ie_d   = status_ie_q;
    cause_bd_d    = cause_bd_q;
    cause_ip_hw_d = {hw_int[5] | timer_ti, hw_int[4:0]};
    cause_ip_sw_d = cause_ip_sw_q;
    cause_exc_d   = cause_exc_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;

    if (mtc0_en) begin
      case (cp0_waddr)
        CP0_STATUS: begin
          status_im_d  = cp0_wdata[STATUS_IM_LSB +: 8];
          status_exl_d = cp0_wdata[STATUS_EXL_BIT];
          status_ie_d  = cp0_wdata[STATUS_IE_BIT];
        end
        CP0_CAUSE: cause_ip_sw_d = cp0_wdata[CAUSE_IP_LSB +: 2];
        CP0_EPC:   epc_d = cp0_wdata;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_REDIR;
          flush_d    = 1'b1;
          pc_clear_d = 1'b1;
          if (exc_take) begin
            cause_exc_d = exc_code;
            if (badv_we) badvaddr_d = badv_val;
            // Nested exceptions keep the original return point
            if (!status_exl_q) begin
              epc_d      = mem_bd ? (mem_pc - WIDTH'(4)) : mem_pc;
              cause_bd_d = mem_bd;
            end
            status_exl_d = 1'b1;
            except_pc_d  = EXC_VEC;
          end else begin
            status_exl_d = 1'b0;
            except_pc_d  = epc_q;
          end
        end
      end
      ST_REDIR: begin
        if (!stall) begin
          state_d    = ST_IDLE;
          flush_d    = 1'b0;
          pc_clear_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      flush_q       <= 1'b0;
      pc_clear_q    <= 1'b0;
      except_pc_q   <= '0;
      status_im_q   <= '0;
      status_exl_q  <= 1'b0;
      status_ie_q   <= 1'b0;
      cause_bd_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      pc_clear_q    <= pc_clear_d;
      except_pc_q   <= except_pc_d;
      status_im_q   <= status_im_d;
      status_exl_q  <= status_exl_d;
      status_ie_q   <= status_ie_d;
      cause_bd_q    <= cause_bd_d;
      cause_ip_hw_q <= cause_ip_hw_d;
      cause_ip_sw_q <= cause_ip_sw_d;
      cause_exc_q   <= cause_exc_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
    end
  end

  always_comb begin
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = timer_count;
      CP0_COMPARE:  cp0_rdata = timer_compare;
      CP0_STATUS:   cp0_rdata = WIDTH'(status_word(status_im_q, status_exl_q, status_ie_q));
      CP0_CAUSE:    cp0_rdata = WIDTH'(cause_word(cause_bd_q, timer_ti,
                                                  {cause_ip_hw_q, cause_ip_sw_q}, cause_exc_q));
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

  assign flush     = flush_q;
  assign pc_clear  = pc_clear_q;
  assign except_pc = except_pc_q;

endmodule

// File: tb/tb_except_redirect_ctrl.sv
// Scoreboard bench for except_redirect_ctrl: expected redirects queued at stimulus, checked on pc_clear.
`timescale 1ns/1ps
module tb_except_redirect_ctrl;
  import except_redirect_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_bd, eret, stall, cp0_we;
  logic [31:0] mem_pc, mem_badaddr, cp0_wdata, cp0_rdata, except_pc;
  logic [6:0]  exc_flags;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic        flush, pc_clear;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] tgt, epc, code, exl, bd, badv;
  } exp_t;
  exp_t sb[$];

  except_redirect_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
    .mem_badaddr(mem_badaddr), .exc_flags(exc_flags), .eret(eret), .hw_int(hw_int),
    .stall(stall), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .flush(flush), .pc_clear(pc_clear),
    .except_pc(except_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    @(negedge clk);
    cp0_we = 1'b0;
  endtask

  task automatic push_exp(input string n, input logic [31:0] tgt, input logic [31:0] epc,
                          input logic [31:0] code, input logic [31:0] exl,
                          input logic [31:0] bd, input logic [31:0] badv);
    exp_t e;
    e.name = n; e.tgt = tgt; e.epc = epc; e.code = code; e.exl = exl; e.bd = bd; e.badv = badv;
    sb.push_back(e);
  endtask

  task automatic fire(input logic [31:0] pc, input logic bd, input logic [6:0] flags,
                      input logic er, input logic [31:0] badaddr);
    mem_valid = 1'b1; mem_pc = pc; mem_bd = bd; exc_flags = flags; eret = er;
    mem_badaddr = badaddr;
    @(negedge clk);
    mem_valid = 1'b0; exc_flags = '0; eret = 1'b0;
  endtask

  // Waits (bounded) for pc_clear, then pops the oldest expectation and compares.
  task automatic expect_redirect(input int bound, output int waited);
    exp_t        e;
    logic [31:0] d;
    waited = 0;
    while (!pc_clear && waited < bound) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (!pc_clear) begin
        check_eq({e.name, "_timeout"}, 32'd0, 32'd1);
      end else begin
        check_eq({e.name, "_flush"}, {31'd0, flush}, 32'd1);
        check_eq({e.name, "_except_pc"}, except_pc, e.tgt);
        rd(CP0_EPC, d);    check_eq({e.name, "_epc"}, d, e.epc);
        rd(CP0_CAUSE, d);  check_eq({e.name, "_exccode"}, {27'd0, d[6:2]}, e.code);
                           check_eq({e.name, "_bd"}, {31'd0, d[31]}, e.bd);
        rd(CP0_STATUS, d); check_eq({e.name, "_exl"}, {31'd0, d[1]}, e.exl);
        rd(CP0_BADVADDR, d); check_eq({e.name, "_badvaddr"}, d, e.badv);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          w, hi;
    rst = 1'b0; mem_valid = 0; mem_pc = 0; mem_bd = 0; mem_badaddr = 0; exc_flags = 0;
    eret = 0; hw_int = 0; stall = 0; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check_eq("rst_flush", {31'd0, flush}, 32'd0);
    check_eq("rst_pc_clear", {31'd0, pc_clear}, 32'd0);
    check_eq("rst_except_pc", except_pc, 32'd0);
    rd(CP0_STATUS, d);   check_eq("rst_status", d, 32'h0040_0000);
    rd(CP0_CAUSE, d);    check_eq("rst_cause", d, 32'd0);
    rd(CP0_EPC, d);      check_eq("rst_epc", d, 32'd0);
    rd(CP0_BADVADDR, d); check_eq("rst_badvaddr", d, 32'd0);
    rd(5'd0, d);         check_eq("unimpl_read", d, 32'd0);
    @(negedge clk);

    // Reset asserted while the redirect is in flight
    fire(32'h8000_0000, 1'b0, 7'b0100000, 1'b0, 32'd0);
    check_eq("t1_in_redir", {31'd0, pc_clear}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t1_rst_flush", {31'd0, flush}, 32'd0);
    check_eq("t1_rst_pc_clear", {31'd0, pc_clear}, 32'd0);
    check_eq("t1_rst_except_pc", except_pc, 32'd0);
    rd(CP0_STATUS, d); check_eq("t1_rst_status", d, 32'h0040_0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    push_exp("t2_ov", EXC_VECTOR, 32'hBFC0_0100, 32'h0C, 1, 0, 0);
    fire(32'hBFC0_0100, 1'b0, 7'b0010000, 1'b0, 32'd0);
    expect_redirect(4, w);
    @(negedge clk);
    check_eq("t2_release", {31'd0, pc_clear}, 32'd0);

    mtc0(CP0_STATUS, 32'd0);
    push_exp("t3_sys_bd", EXC_VECTOR, 32'hBFC0_0204, 32'h08, 1, 1, 0);
    fire(32'hBFC0_0208, 1'b1, 7'b0001000, 1'b0, 32'd0);
    expect_redirect(4, w);
    @(negedge clk);

    // EXL already set: EPC and BD must survive a second exception
    push_exp("t3_bp_nested", EXC_VECTOR, 32'hBFC0_0204, 32'h09, 1, 1, 0);
    fire(32'h1234_5678, 1'b0, 7'b0000100, 1'b0, 32'd0);
    expect_redirect(4, w);
    @(negedge clk);

    mtc0(CP0_EPC, 32'h8000_1000);
    push_exp("t4_eret", 32'h8000_1000, 32'h8000_1000, 32'h09, 0, 1, 0);
    fire(32'h8000_0ffc, 1'b0, 7'd0, 1'b1, 32'd0);
    stall = 1'b1;
    expect_redirect(4, w);
    hi = pc_clear ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (pc_clear) hi++;
      if (i == 3) stall = 1'b0;
    end
    check_eq("t4_pc_clear_cycles", hi, 32'd4);

    mtc0(CP0_COMPARE, 32'd10);
    mtc0(CP0_COUNT, 32'd0);
    mtc0(CP0_STATUS, 32'h0000_8001);
    push_exp("t5_timer_int", EXC_VECTOR, 32'h8000_2000, 32'h00, 1, 0, 0);
    mem_valid = 1'b1; mem_pc = 32'h8000_2000; mem_bd = 1'b0; exc_flags = '0;
    expect_redirect(80, w);
    mem_valid = 1'b0;
    check_eq("t5_latency_window", {31'd0, (w >= 12 && w <= 30)}, 32'd1);
    @(negedge clk);
    rd(CP0_CAUSE, d);
    check_eq("t5_ip7_set", {31'd0, d[15]}, 32'd1);
    check_eq("t5_ti_set", {31'd0, d[30]}, 32'd1);
    rd(CP0_STATUS, d); check_eq("t5_status", d, 32'h0040_8003);
    mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(CP0_CAUSE, d);
    check_eq("t5_ip7_clear", {31'd0, d[15]}, 32'd0);
    check_eq("t5_ti_clear", {31'd0, d[30]}, 32'd0);

    mtc0(CP0_STATUS, 32'h0000_0401);
    hw_int = 6'b000001;
    repeat (2) @(negedge clk);
    push_exp("t6_int_wins", EXC_VECTOR, 32'h8000_3000, 32'h00, 1, 0, 0);
    fire(32'h8000_3000, 1'b0, 7'b0000010, 1'b0, 32'h8000_0003);
    expect_redirect(4, w);
    @(negedge clk);
    mtc0(CP0_STATUS, 32'h0000_0400);
    push_exp("t6_adel_ld", EXC_VECTOR, 32'h8000_3000, 32'h04, 1, 0, 32'h8000_0003);
    fire(32'h8000_3000, 1'b0, 7'b0000010, 1'b0, 32'h8000_0003);
    expect_redirect(4, w);
    @(negedge clk);
    hw_int = 6'd0;

    mtc0(CP0_STATUS, 32'd0);
    push_exp("t7_ri_first", EXC_VECTOR, 32'h8000_4000, 32'h0A, 1, 0, 32'h8000_0003);
    fire(32'h8000_4000, 1'b0, 7'b0110001, 1'b0, 32'h9000_0000);
    expect_redirect(4, w);
    @(negedge clk);

    push_exp("t8_adel_if", EXC_VECTOR, 32'h8000_4000, 32'h04, 1, 0, 32'h8000_5001);
    fire(32'h8000_5001, 1'b0, 7'b1000010, 1'b0, 32'h9000_0000);
    expect_redirect(4, w);
    @(negedge clk);

    mtc0(CP0_BADVADDR, 32'h1111_1111);
    rd(CP0_BADVADDR, d); check_eq("t9_badvaddr_ro", d, 32'h8000_5001);

    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    rd(CP0_COUNT, d); check_eq("t10_count_wrap", {31'd0, (d < 32'd4)}, 32'd1);

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
